lap_store: RTL and testbench
============================

# lap_store

Lap memory for stopwatch mode, placed between the four BCD digit counters and the seven-segment driver. On each lap pulse it captures the current mm:ss digits into a ring buffer of DEPTH entries. While live, it passes the running digits through to the display. In recall mode it presents a stored lap instead, so the user can step through past laps without disturbing the running count.

## Interface
Parameters:
- DEPTH, 8: number of lap entries; power of two, 2..16.
- IDX_W, 4: width of o_index/o_count; must hold DEPTH.

Ports:
- i_clk  in  1  system clock (the 1 kHz design clock).
- i_reset  in  1  reset; synchronous, active-high.
- i_digits  in  16  live time {d3,d2,d1,d0}, BCD: minutes tens, minutes ones, seconds tens, seconds ones.
- i_capture  in  1  one-cycle lap pulse (debounced button).
- i_recall_next  in  1  one-cycle pulse: step to an older lap.
- i_recall_prev  in  1  one-cycle pulse: step to a newer lap.
- i_clear  in  1  one-cycle pulse: empty the buffer and return to LIVE.
- o_digits  out  16  digits to the display driver.
- o_recall  out  1  high while in RECALL.
- o_index  out  IDX_W  age of the shown lap (1 = newest); 0 in LIVE.
- o_count  out  IDX_W  number of valid entries, 0..DEPTH.
- o_full  out  1  o_count == DEPTH.
- o_overflow  out  1  sticky; set when a capture overwrites the oldest entry.

## Operation
- Storage: a register array mem[DEPTH], a write pointer wp, and a count. Reads are asynchronous.
- Capture (accepted in any state):
  - Writes mem[wp] <= value, then wp <= wp+1 mod DEPTH.
  - Increments count, saturating at DEPTH.
  - If count was already DEPTH, the oldest entry is overwritten and o_overflow is set.
- States:
  - LIVE: o_digits = i_digits, o_index = 0.
    - i_recall_next with count>0 goes to RECALL with index=1.
    - i_recall_prev is ignored.
    - With count=0, both recall pulses are ignored.
  - RECALL: o_digits = mem[(wp - index) mod DEPTH].
    - i_recall_next: index+1. If index == count, go to LIVE instead.
    - i_recall_prev: index-1. If index == 1, go to LIVE instead.
    - A capture in RECALL increments index (unless index==count==DEPTH), so the same lap stays on display.
- Clear:
  - Sets wp=0, count=0, o_overflow=0, state=LIVE.
  - Resets the last-capture register (see Configuration) to 0000.
  - Entry contents are not zeroed.
- Simultaneous pulse priority: clear > capture > recall_next > recall_prev.
  - A capture in the same cycle as a recall pulse: capture is performed, the recall pulse is dropped.
- All digit values are 4-bit BCD. No arithmetic is done on them except under LAP_SPLIT_EN.

## Timing
- Reset values: state LIVE, wp 0, count 0, o_recall 0, o_index 0, o_count 0, o_full 0, o_overflow 0. o_digits follows i_digits, since the state is LIVE.
- LIVE path is combinational: zero-cycle latency from i_digits to o_digits.
- A capture pulse in cycle N makes the entry, o_count, o_full and o_overflow visible from cycle N+1.
- A recall pulse in cycle N changes state, index, o_recall and o_digits in cycle N+1.
- Clear in cycle N: all outputs are at reset values in cycle N+1.
- Reset asserted mid-operation has the same effect as clear, and also forces the reset values above.
- Input pulses longer than one cycle are treated as one event per high cycle. Callers supply single-cycle pulses.

## Configuration
- LAP_SPLIT_EN defined:
  - Each entry stores the split, i.e. the current time minus the previously captured absolute time.
  - Subtraction is computed combinationally in the capture cycle.
  - Seconds are subtracted mod 60 with a borrow into minutes; minutes are subtracted mod 100.
  - A last_abs register holds the previous capture's absolute time. It is reset to 0000 by reset or clear, so the first split equals the absolute time.
- LAP_SPLIT_EN undefined:
  - Entries store the absolute i_digits.
  - No last_abs register or subtractor is built.

## Test plan
- Capture at 00:12, 00:47, 01:05 (hex 0012, 0047, 0105) -> o_count=3. Recall_next x1 shows 0105 with o_index=1; x3 shows 0012; a 4th returns to LIVE with o_digits=i_digits.
- DEPTH+2 captures of 0001..0010 (DEPTH=8) -> o_count=8, o_full=1, o_overflow=1. Oldest recalled (index 8) = 0003.
- In RECALL at index 2, capture 0230 -> o_index=3 and o_digits unchanged. Recall_prev x3 -> LIVE.
- Capture and clear in the same cycle -> o_count=0, o_overflow=0, LIVE. Recall_next is then ignored (o_recall stays 0).
- Synchronous reset while in RECALL with count=5 -> all outputs reach reset values next cycle, and o_digits tracks i_digits.
- LAP_SPLIT_EN: captures at 0050 then 0115 -> entries 0050 and 0025 (borrow across the minute). Wrap case: 9959 then 0004 -> split 0005.

Source files
------------

// File: rtl/lap_store_if.sv
// rtl/lap_store_if.sv - lap memory bundle between stopwatch counters and display driver
// Ports carried:
//   i_digits      [15:0]  live time {min tens, min ones, sec tens, sec ones}, BCD
//   i_capture             one-cycle lap pulse
//   i_recall_next         one-cycle pulse, step to an older lap
//   i_recall_prev         one-cycle pulse, step to a newer lap
//   i_clear               one-cycle pulse, empty the buffer
//   o_digits      [15:0]  digits to the seven-segment driver
//   o_recall              high while a stored lap is shown
//   o_index  [IDX_W-1:0]  age of the shown lap (1 = newest), 0 when live
//   o_count  [IDX_W-1:0]  number of valid entries
//   o_full                buffer holds DEPTH entries
//   o_overflow            sticky, an old lap was overwritten
// master: stopwatch side; slave: lap_store.
interface lap_store_if #(
  parameter int IDX_W = 4
);
  logic [15:0]      i_digits;
  logic             i_capture;
  logic             i_recall_next;
  logic             i_recall_prev;
  logic             i_clear;
  logic [15:0]      o_digits;
  logic             o_recall;
  logic [IDX_W-1:0] o_index;
  logic [IDX_W-1:0] o_count;
  logic             o_full;
  logic             o_overflow;

  modport master (
    output i_digits, i_capture, i_recall_next, i_recall_prev, i_clear,
    input  o_digits, o_recall, o_index, o_count, o_full, o_overflow
  );

  modport slave (
    input  i_digits, i_capture, i_recall_next, i_recall_prev, i_clear,
    output o_digits, o_recall, o_index, o_count, o_full, o_overflow
  );
endinterface

// File: rtl/lap_store.sv
// rtl/lap_store.sv - stopwatch lap ring buffer with live pass-through and recall
// Ports:
//   i_clk    system clock
//   i_reset  synchronous active-high reset
//   bus      lap_store_if.slave (live digits and pulses in, display/status out)
// Optional feature: define LAP_SPLIT_EN to store split times (current minus
// previous capture) instead of absolute times.
module lap_store #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  lap_store_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] FULL_CNT = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  typedef enum logic {S_LIVE, S_RECALL} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      mem_q [DEPTH];
  logic [15:0]      mem_d [DEPTH];
  logic [15:0]      cap_val;
  logic [PTR_W-1:0] rd_ptr;

`ifdef LAP_SPLIT_EN
  logic [15:0] last_abs_q, last_abs_d;
  logic [7:0]  sec_cur, sec_prev, min_cur, min_prev;
  logic [7:0]  sec_diff, min_tmp, min_diff;
  logic        sec_borrow;

  // Split = now - last capture; seconds wrap at 60 borrowing a minute,
  // minutes wrap at 100. Done in binary then converted back to BCD.
  always_comb begin
    sec_cur    = 8'(bus.i_digits[7:4]) * 8'd10 + 8'(bus.i_digits[3:0]);
    sec_prev   = 8'(last_abs_q[7:4]) * 8'd10 + 8'(last_abs_q[3:0]);
    min_cur    = 8'(bus.i_digits[15:12]) * 8'd10 + 8'(bus.i_digits[11:8]);
    min_prev   = 8'(last_abs_q[15:12]) * 8'd10 + 8'(last_abs_q[11:8]);
    sec_borrow = sec_cur < sec_prev;
    sec_diff   = sec_borrow ? (sec_cur + 8'd60 - sec_prev) : (sec_cur - sec_prev);
    min_tmp    = min_cur + 8'd100 - min_prev - 8'(sec_borrow);
    min_diff   = (min_tmp >= 8'd100) ? (min_tmp - 8'd100) : min_tmp;
    cap_val    = {4'(min_diff / 8'd10), 4'(min_diff % 8'd10),
                  4'(sec_diff / 8'd10), 4'(sec_diff % 8'd10)};
  end
`else
  assign cap_val = bus.i_digits;
`endif

  // Priority: clear > capture > recall_next > recall_prev.
  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    count_d    = count_q;
    index_d    = index_q;
    overflow_d = overflow_q;
    mem_d      = mem_q;
`ifdef LAP_SPLIT_EN
    last_abs_d = last_abs_q;
`endif
    if (bus.i_clear) begin
      state_d    = S_LIVE;
      wp_d       = '0;
      count_d    = '0;
      index_d    = '0;
      overflow_d = 1'b0;
`ifdef LAP_SPLIT_EN
      last_abs_d = '0;
`endif
    end else if (bus.i_capture) begin
      mem_d[wp_q] = cap_val;
      wp_d        = wp_q + 1'b1;
`ifdef LAP_SPLIT_EN
      last_abs_d  = bus.i_digits;
`endif
      if (count_q == FULL_CNT) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + ONE;
      end
      // Age of the shown lap grows by one so the same lap stays on screen;
      // when the oldest slot is shown in a full buffer it is the one being
      // overwritten, so the index has nowhere to go.
      if (state_q == S_RECALL && !(index_q == FULL_CNT && count_q == FULL_CNT)) begin
        index_d = index_q + ONE;
      end
    end else if (bus.i_recall_next) begin
      if (state_q == S_LIVE) begin
        if (count_q != '0) begin
          state_d = S_RECALL;
          index_d = ONE;
        end
      end else if (index_q == count_q) begin
        state_d = S_LIVE;
        index_d = '0;
      end else begin
        index_d = index_q + ONE;
      end
    end else if (bus.i_recall_prev) begin
      if (state_q == S_RECALL) begin
        if (index_q == ONE) begin
          state_d = S_LIVE;
          index_d = '0;
        end else begin
          index_d = index_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_LIVE;
      wp_q       <= '0;
      count_q    <= '0;
      index_q    <= '0;
      overflow_q <= 1'b0;
`ifdef LAP_SPLIT_EN
      last_abs_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      count_q    <= count_d;
      index_q    <= index_d;
      overflow_q <= overflow_d;
`ifdef LAP_SPLIT_EN
      last_abs_q <= last_abs_d;
`endif
    end
  end

  // Entry contents survive reset/clear; count and wp decide what is valid.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  // index == DEPTH truncates to 0, which is the right ring offset.
  assign rd_ptr = wp_q - index_q[PTR_W-1:0];

  assign bus.o_digits   = (state_q == S_RECALL) ? mem_q[rd_ptr] : bus.i_digits;
  assign bus.o_recall   = (state_q == S_RECALL);
  assign bus.o_index    = index_q;
  assign bus.o_count    = count_q;
  assign bus.o_full     = (count_q == FULL_CNT);
  assign bus.o_overflow = overflow_q;
endmodule

// File: tb/tb_lap_store.sv
// tb/tb_lap_store.sv - self-checking bench for lap_store
module tb_lap_store;
  localparam int DEPTH = 8;
  localparam int IDX_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  lap_store_if #(.IDX_W(IDX_W)) bus ();

  lap_store #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: laps kept newest-first in a queue; shown lap is laps[idx-1].
  logic [15:0] m_laps[$];
  bit          m_recall = 1'b0;
  int          m_idx    = 0;
  bit          m_ovf    = 1'b0;
`ifdef LAP_SPLIT_EN
  logic [15:0] m_last   = 16'h0;

  function automatic logic [15:0] split_of(input logic [15:0] cur, input logic [15:0] prev);
    int c, p, d, m, s;
    c = (int'(cur[15:12]) * 10 + int'(cur[11:8])) * 60 + int'(cur[7:4]) * 10 + int'(cur[3:0]);
    p = (int'(prev[15:12]) * 10 + int'(prev[11:8])) * 60 + int'(prev[7:4]) * 10 + int'(prev[3:0]);
    d = ((c - p) % 6000 + 6000) % 6000;
    m = d / 60;
    s = d % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction
`endif

  // Inputs change at negedge+1, so at each negedge they still hold the values
  // the DUT sampled at the preceding posedge: advance the model, then compare.
  always @(negedge clk) begin
    logic [15:0] v;
    logic [15:0] exp_d;
    if (rst || bus.i_clear) begin
      m_laps.delete();
      m_recall = 1'b0;
      m_idx    = 0;
      m_ovf    = 1'b0;
`ifdef LAP_SPLIT_EN
      m_last   = 16'h0;
`endif
    end else if (bus.i_capture) begin
`ifdef LAP_SPLIT_EN
      v      = split_of(bus.i_digits, m_last);
      m_last = bus.i_digits;
`else
      v      = bus.i_digits;
`endif
      m_laps.push_front(v);
      if (m_laps.size() > DEPTH) begin
        void'(m_laps.pop_back());
        m_ovf = 1'b1;
      end
      if (m_recall && m_idx < m_laps.size()) m_idx++;
    end else if (bus.i_recall_next) begin
      if (!m_recall) begin
        if (m_laps.size() > 0) begin
          m_recall = 1'b1;
          m_idx    = 1;
        end
      end else begin
        m_idx++;
        if (m_idx > m_laps.size()) begin
          m_recall = 1'b0;
          m_idx    = 0;
        end
      end
    end else if (bus.i_recall_prev) begin
      if (m_recall) begin
        m_idx--;
        if (m_idx == 0) m_recall = 1'b0;
      end
    end

    exp_d = m_recall ? m_laps[m_idx-1] : bus.i_digits;
    check("cyc_o_digits",   bus.o_digits,           exp_d);
    check("cyc_o_recall",   16'(bus.o_recall),      16'(m_recall));
    check("cyc_o_index",    16'(bus.o_index),       16'(m_idx));
    check("cyc_o_count",    16'(bus.o_count),       16'(m_laps.size()));
    check("cyc_o_full",     16'(bus.o_full),        16'(m_laps.size() == DEPTH));
    check("cyc_o_overflow", 16'(bus.o_overflow),    16'(m_ovf));
  end

  task automatic pulse(input bit cap, input bit nxt, input bit prv, input bit clr);
    @(negedge clk); #1;
    bus.i_capture     = cap;
    bus.i_recall_next = nxt;
    bus.i_recall_prev = prv;
    bus.i_clear       = clr;
    @(negedge clk); #1;
    bus.i_capture     = 1'b0;
    bus.i_recall_next = 1'b0;
    bus.i_recall_prev = 1'b0;
    bus.i_clear       = 1'b0;
  endtask

  task automatic cap(input logic [15:0] d);
    bus.i_digits = d;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst               = 1'b1;
    bus.i_digits      = 16'h0000;
    bus.i_capture     = 1'b0;
    bus.i_recall_next = 1'b0;
    bus.i_recall_prev = 1'b0;
    bus.i_clear       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_count",    16'(bus.o_count),    16'h0);
    check("rst_recall",   16'(bus.o_recall),   16'h0);
    check("rst_overflow", 16'(bus.o_overflow), 16'h0);
    check("rst_full",     16'(bus.o_full),     16'h0);
    check("rst_digits",   bus.o_digits,        16'h0000);
    rst = 1'b0;

    // Three laps, step back through them and out to live.
    cap(16'h0012); cap(16'h0047); cap(16'h0105);
    check("t1_count", 16'(bus.o_count), 16'h3);
    bus.i_digits = 16'h0200;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("t1_n1_index",  16'(bus.o_index),  16'h1);
    check("t1_n1_recall", 16'(bus.o_recall), 16'h1);
`ifndef LAP_SPLIT_EN
    check("t1_n1_digits", bus.o_digits, 16'h0105);
`endif
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("t1_n3_index", 16'(bus.o_index), 16'h3);
`ifndef LAP_SPLIT_EN
    check("t1_n3_digits", bus.o_digits, 16'h0012);
`endif
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("t1_n4_recall", 16'(bus.o_recall), 16'h0);
    check("t1_n4_digits", bus.o_digits,      16'h0200);

    // DEPTH+2 captures: wrap, full, overflow.
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= DEPTH + 2; i++) cap({8'h00, 4'(i / 10), 4'(i % 10)});
    check("t2_count",    16'(bus.o_count),    16'h8);
    check("t2_full",     16'(bus.o_full),     16'h1);
    check("t2_overflow", 16'(bus.o_overflow), 16'h1);
    repeat (DEPTH) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("t2_oldest_index", 16'(bus.o_index), 16'h8);
`ifndef LAP_SPLIT_EN
    check("t2_oldest_digits", bus.o_digits, 16'h0003);
    check("t2_model_oldest",  m_laps[DEPTH-1], 16'h0003);
`endif
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("t2_back_live", 16'(bus.o_recall), 16'h0);

    // Capture while recalling keeps the same lap on display.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    cap(16'h0230);
    check("t3_index", 16'(bus.o_index), 16'h3);
`ifndef LAP_SPLIT_EN
    check("t3_digits", bus.o_digits, 16'h0009);
`endif
    repeat (3) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_prev_live", 16'(bus.o_recall), 16'h0);

    // Oldest shown in a full buffer: index pinned, next-oldest appears.
    repeat (DEPTH) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    cap(16'h0300);
    check("t3b_index", 16'(bus.o_index), 16'h8);
`ifndef LAP_SPLIT_EN
    check("t3b_digits", bus.o_digits, 16'h0005);
`endif

    // Capture and clear together: clear wins.
    bus.i_digits = 16'h0411;
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    check("t4_count",    16'(bus.o_count),    16'h0);
    check("t4_overflow", 16'(bus.o_overflow), 16'h0);
    check("t4_recall",   16'(bus.o_recall),   16'h0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_next_ignored", 16'(bus.o_recall), 16'h0);

    // recall_prev ignored in LIVE; capture beats recall_next.
    cap(16'h0101);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_prev_ignored", 16'(bus.o_recall), 16'h0);
    bus.i_digits = 16'h0102;
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_cap_wins_count",  16'(bus.o_count),  16'h2);
    check("t5_cap_wins_recall", 16'(bus.o_recall), 16'h0);

    // Reset while recalling with five entries.
    cap(16'h0103); cap(16'h0104); cap(16'h0105);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("t6_pre_count", 16'(bus.o_count), 16'h5);
    @(negedge clk); #1; rst = 1'b1;
    @(negedge clk); #1; rst = 1'b0;
    check("t6_count",    16'(bus.o_count),    16'h0);
    check("t6_recall",   16'(bus.o_recall),   16'h0);
    check("t6_index",    16'(bus.o_index),    16'h0);
    check("t6_full",     16'(bus.o_full),     16'h0);
    check("t6_overflow", 16'(bus.o_overflow), 16'h0);
    bus.i_digits = 16'h1234;
    #1;
    check("t6_live_digits", bus.o_digits, 16'h1234);

    // Split arithmetic cases (absolute values without LAP_SPLIT_EN).
    cap(16'h0050); cap(16'h0115);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef LAP_SPLIT_EN
    check("t7_split_borrow", bus.o_digits, 16'h0025);
`else
    check("t7_abs_second", bus.o_digits, 16'h0115);
`endif
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("t7_first", bus.o_digits, 16'h0050);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    cap(16'h9959); cap(16'h0004);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef LAP_SPLIT_EN
    check("t7_split_wrap", bus.o_digits, 16'h0005);
`else
    check("t7_abs_wrap", bus.o_digits, 16'h0004);
`endif
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("t7_wrap_first", bus.o_digits, 16'h9959);

    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
